// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter.
// A 10-bit frame {stop, data, start} is loaded on an accepted trmt request and
// shifted out LSB first, one bit every BAUD_CYCLES clocks. The TX line is the
// LSB of the frame register, so it is always driven straight from a flop.
// tx_done is raised when the frame completes and stays high until the next
// request is accepted. tx_busy is high exactly while a frame is in flight.
module uart_tx #(
    parameter int BAUD_CYCLES = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done,
    output logic       tx_busy
);

    // Baud counter width; clamped to one bit so tiny BAUD_CYCLES values still elaborate.
    localparam int CW = (BAUD_CYCLES > 1) ? $clog2(BAUD_CYCLES) : 1;

    // Last count value of a bit period; the shift happens on the edge that sees it.
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CYCLES - 1);
    localparam logic [CW-1:0] BAUD_ZERO = CW'(0);
    localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

    // Number of the final shift (stop bit leaves the line) before wrapping to IDLE.
    localparam logic [3:0] LAST_BIT_IDX = 4'd9;

    // Idle line level for the whole frame register: all ones.
    localparam logic [9:0] FRAME_IDLE = 10'h3FF;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        TRANSMIT = 1'b1
    } state_e;

    state_e        state_q,    state_d;
    logic [9:0]    frame_q,    frame_d;
    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]    bit_cnt_q,  bit_cnt_d;
    logic          tx_done_q,  tx_done_d;
    logic          tx_busy_q,  tx_busy_d;

    logic          load_s;
    logic          shift_s;
    logic          last_shift_s;

    // Builds the serial frame: start bit (0) at bit 0, data LSB first, stop bit (1) on top.
    function automatic logic [9:0] build_frame(input logic [7:0] data);
        build_frame = {1'b1, data, 1'b0};
    endfunction

    // Shifts the frame one bit toward the line, back-filling with the idle level.
    function automatic logic [9:0] shift_frame(input logic [9:0] frame);
        shift_frame = {1'b1, frame[9:1]};
    endfunction

    // Decodes the per-cycle events: request acceptance, bit-period end, final bit.
    always_comb begin
        load_s       = (state_q == IDLE) && trmt;
        shift_s      = (state_q == TRANSMIT) && (baud_cnt_q == BAUD_LAST);
        last_shift_s = shift_s && (bit_cnt_q == LAST_BIT_IDX);
    end

    // Next-state logic for the FSM, frame shifter, counters and status flags.
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_done_d  = tx_done_q;

        case (state_q)
            IDLE: begin
                if (load_s) begin
                    // Accepting a request drops TX to the start bit on this same edge
                    // and clears the previous completion flag.
                    state_d    = TRANSMIT;
                    frame_d    = build_frame(tx_data);
                    baud_cnt_d = BAUD_ZERO;
                    bit_cnt_d  = 4'd0;
                    tx_done_d  = 1'b0;
                end else begin
                    // Line stays idle; tx_done keeps whatever the last frame left.
                    state_d = IDLE;
                end
            end

            TRANSMIT: begin
                // trmt is deliberately not looked at here, including on the final edge.
                if (shift_s) begin
                    frame_d    = shift_frame(frame_q);
                    baud_cnt_d = BAUD_ZERO;
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    if (last_shift_s) begin
                        // Frame register is all ones by now, so TX rests high.
                        state_d   = IDLE;
                        tx_done_d = 1'b1;
                    end else begin
                        state_d = TRANSMIT;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_ONE;
                end
            end

            default: begin
                // Unreachable encoding: fall back to a quiet idle line.
                state_d    = IDLE;
                frame_d    = FRAME_IDLE;
                baud_cnt_d = BAUD_ZERO;
                bit_cnt_d  = 4'd0;
                tx_done_d  = 1'b0;
            end
        endcase

        // Busy mirrors the registered state exactly.
        tx_busy_d = (state_d == TRANSMIT);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            frame_q    <= FRAME_IDLE;
            baud_cnt_q <= BAUD_ZERO;
            bit_cnt_q  <= 4'd0;
            tx_done_q  <= 1'b0;
            tx_busy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_done_q  <= tx_done_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    assign TX      = frame_q[0];
    assign tx_done = tx_done_q;
    assign tx_busy = tx_busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx.
// A fast instance (16 clocks/bit) takes directed and randomized requests; the
// driver predicts acceptance from frame timing alone and queues the expected
// byte with its acceptance cycle. A monitor detects each start bit, samples
// every bit at its centre and checks data, start time and completion timing.
// A default-rate instance then checks the reference 0xA5 frame end to end.
module tb_uart_tx;

    localparam int SB = 16;    // bit period of the fast instance
    localparam int BB = 2604;  // default bit period

    typedef struct {
        logic [7:0]  data;
        int unsigned c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n_s;
    logic       trmt_s;
    logic [7:0] tx_data_s;
    logic       tx_s, tx_done_s, tx_busy_s;

    logic       trmt_b;
    logic [7:0] tx_data_b;
    logic       tx_b, tx_done_b, tx_busy_b;

    int unsigned cyc = 0;
    int unsigned free_cyc;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        mon_en;
    exp_t        sb_q[$];

    uart_tx #(.BAUD_CYCLES(SB)) u_dut (
        .clk(clk), .rst_n(rst_n_s), .trmt(trmt_s), .tx_data(tx_data_s),
        .TX(tx_s), .tx_done(tx_done_s), .tx_busy(tx_busy_s)
    );

    uart_tx u_big (
        .clk(clk), .rst_n(rst_n_s), .trmt(trmt_b), .tx_data(tx_data_b),
        .TX(tx_b), .tx_done(tx_done_b), .tx_busy(tx_busy_b)
    );

    always #5 clk = ~clk;

    // Counts rising edges so every event can be placed on an absolute edge index.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Raise trmt for 'hold' edges; the model accepts only when no frame is running.
    task automatic send(input logic [7:0] b, input int hold);
        exp_t e;
        trmt_s    = 1'b1;
        tx_data_s = b;
        for (int h = 0; h < hold; h++) begin
            if (rst_n_s && (cyc + 1 >= free_cyc)) begin
                e.data = b;
                e.c    = cyc + 1;
                sb_q.push_back(e);
                free_cyc = cyc + 1 + 10 * SB + 1;
            end
            @(negedge clk);
        end
        trmt_s    = 1'b0;
        tx_data_s = 8'($urandom);
    endtask

    task automatic wait_free();
        while (cyc + 1 < free_cyc) @(negedge clk);
    endtask

    // Monitor: each falling TX edge must match the oldest queued frame.
    initial begin : monitor
        exp_t       e;
        logic [9:0] fr;
        forever begin
            @(negedge clk);
            if (mon_en === 1'b1 && tx_s === 1'b0) begin
                check("frame_expected", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("start_cycle", cyc, e.c);
                    check("start_flags", {tx_done_s, tx_busy_s}, 2'b01);
                    repeat (SB / 2) @(negedge clk);
                    fr[0] = tx_s;
                    for (int k = 1; k < 10; k++) begin
                        repeat (SB) @(negedge clk);
                        fr[k] = tx_s;
                    end
                    check("frame_bits", fr, {1'b1, e.data, 1'b0});
                    repeat (SB / 2 - 1) @(negedge clk);
                    check("done_before_end", {tx_done_s, tx_busy_s}, 2'b01);
                    @(negedge clk);
                    check("done_at_end", {tx_done_s, tx_busy_s, tx_s}, 3'b101);
                end else begin
                    repeat (10 * SB) @(negedge clk);
                end
            end
        end
    end

    // Hard time limit so the run can never hang.
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [9:0]  f81;
        logic [9:0]  a5f;
        logic        ok;
        logic        prev_done;
        int          rises;
        int unsigned c0;
        int unsigned n;
        int          mode;

        rst_n_s   = 1'b0;
        trmt_s    = 1'b0;
        tx_data_s = 8'h00;
        trmt_b    = 1'b0;
        tx_data_b = 8'h00;
        mon_en    = 1'b0;
        free_cyc  = 0;

        repeat (3) @(negedge clk);
        check("reset_small", {tx_s, tx_done_s, tx_busy_s}, 3'b100);
        check("reset_big",   {tx_b, tx_done_b, tx_busy_b}, 3'b100);
        rst_n_s = 1'b1;
        mon_en  = 1'b1;

        // Back-to-back: 0x00 accepted on the first idle edge after a 0xFF frame.
        send(8'hFF, 1);
        wait_free();
        send(8'h00, 1);

        // trmt held three edges: only the first is accepted.
        wait_free();
        repeat (5) @(negedge clk);
        send(8'hC3, 3);

        // Randomized mix of back-to-back, gapped and mid-frame requests.
        for (int i = 0; i < 24; i++) begin
            mode = int'($urandom_range(0, 3));
            if (mode == 0) begin
                wait_free();
            end else if (mode == 1) begin
                wait_free();
                repeat ($urandom_range(1, 20)) @(negedge clk);
            end else if (mode == 2) begin
                repeat ($urandom_range(1, 150)) @(negedge clk);
            end else begin
                @(negedge clk);
            end
            send(8'($urandom), int'($urandom_range(1, 3)));
        end
        wait_free();
        repeat (20) @(negedge clk);
        check("sb_drained", sb_q.size(), 32'd0);
        check("done_held", {tx_done_s, tx_busy_s, tx_s}, 3'b101);

        // Reset during bit 4 of a 0x81 frame, with trmt also high on the reset edge.
        mon_en = 1'b0;
        f81 = {1'b1, 8'h81, 1'b0};
        send(8'h81, 1);
        repeat (4 * SB + SB / 2) @(negedge clk);
        check("pre_reset_bit4", {tx_s, tx_busy_s}, {f81[4], 1'b1});
        rst_n_s   = 1'b0;
        trmt_s    = 1'b1;
        tx_data_s = 8'h42;
        @(negedge clk);
        check("abort_state", {tx_s, tx_busy_s, tx_done_s}, 3'b100);
        rst_n_s = 1'b1;
        trmt_s  = 1'b0;
        sb_q.delete();
        free_cyc = cyc + 1;
        ok = 1'b1;
        repeat (12 * SB) begin
            @(negedge clk);
            if (tx_s !== 1'b1 || tx_done_s !== 1'b0 || tx_busy_s !== 1'b0) ok = 1'b0;
        end
        check("stays_idle_after_reset", ok, 1'b1);
        mon_en = 1'b1;
        send(8'h5A, 1);
        wait_free();
        repeat (5) @(negedge clk);
        check("sb_drained_after_reset", sb_q.size(), 32'd0);

        // Default-rate 0xA5 frame with an ignored 0x3C request 5000 cycles in.
        a5f       = {1'b1, 8'hA5, 1'b0};
        trmt_b    = 1'b1;
        tx_data_b = 8'hA5;
        @(negedge clk);
        c0        = cyc;
        trmt_b    = 1'b0;
        tx_data_b = 8'h00;
        check("big_start", {tx_b, tx_done_b, tx_busy_b}, 3'b001);
        ok        = 1'b1;
        rises     = 0;
        prev_done = tx_done_b;
        n         = 0;
        while (n < 10 * BB + 40) begin
            @(negedge clk);
            n = cyc - c0;
            if (tx_done_b === 1'b1 && prev_done !== 1'b1) rises++;
            prev_done = tx_done_b;
            if (n == 4999) begin
                trmt_b    = 1'b1;
                tx_data_b = 8'h3C;
            end else if (n == 5000) begin
                trmt_b    = 1'b0;
                tx_data_b = 8'($urandom);
            end
            if (n < 10 * BB && (n % BB) == BB / 2) begin
                check("big_bit_level", tx_b, a5f[n / BB]);
            end
            if (n == 10 * BB - 1) check("big_done_early", {tx_done_b, tx_busy_b}, 2'b01);
            if (n == 10 * BB)     check("big_done_time",  {tx_done_b, tx_busy_b, tx_b}, 3'b101);
            if (n > 10 * BB && (tx_b !== 1'b1 || tx_busy_b !== 1'b0)) ok = 1'b0;
        end
        check("big_no_second_frame", ok, 1'b1);
        check("big_done_rises_once", rises, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
